// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: fetch-stage state encodings,
// the architectural NOP and next-PC helpers.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } if_state_e;

  // Branch displacement: sign-extended word offset converted to bytes.
  function automatic logic [31:0] branch_disp(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC generation: sequential, branch and jump targets plus
// the redirect/stall selection for the RUN state.
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] if_id_pc_plus4_i,
  input  logic        if_id_valid_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] seq_o,
  output logic [31:0] btgt_o,
  output logic [31:0] jtgt_o,
  output logic [31:0] npc_o,
  output logic        redirect_o,
  output logic        hold_o
);

  logic take_jump;
  logic take_branch;

  always_comb begin
    seq_o  = pc_i + 32'(WORD_BYTES);
    btgt_o = if_id_pc_plus4_i + branch_disp(branch_offset_i);
    jtgt_o = {if_id_pc_plus4_i[31:28], jump_index_i, 2'b00};
  end

  // A redirect belongs to the instruction in IF/ID, so a bubble there cannot redirect.
  always_comb begin
    take_jump   = jump_i && if_id_valid_i;
    take_branch = branch_taken_i && if_id_valid_i && !take_jump;
    redirect_o  = take_jump || take_branch;
    hold_o      = stall_i && !redirect_o;
    npc_o       = seq_o;
    if (take_jump) begin
      npc_o = jtgt_o;
    end else if (take_branch) begin
      npc_o = btgt_o;
    end else if (stall_i) begin
      npc_o = pc_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives Imem, captures the IF/ID
// register and stops on halt or an out-of-range fetch.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_WORDS) * 33'(WORD_BYTES);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [31:0] seq, btgt, jtgt, npc;
  logic        redirect, hold;
  logic        bad_fetch;

  next_pc u_next_pc (
    .pc_i             (pc_q),
    .if_id_pc_plus4_i (pp4_q),
    .if_id_valid_i    (valid_q),
    .stall_i          (stall),
    .branch_taken_i   (branch_taken),
    .branch_offset_i  (branch_offset),
    .jump_i           (jump),
    .jump_index_i     (jump_index),
    .seq_o            (seq),
    .btgt_o           (btgt),
    .jtgt_o           (jtgt),
    .npc_o            (npc),
    .redirect_o       (redirect),
    .hold_o           (hold)
  );

  // Widened compare so IMEM_WORDS*4 never wraps.
  assign bad_fetch = ({1'b0, pc_q} >= FETCH_LIMIT) || (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp4_d    = pp4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (bad_fetch) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          instr_d = NOP_INSTR;
          pp4_d   = '0;
          valid_d = 1'b0;
        end else if (halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
          instr_d  = NOP_INSTR;
          pp4_d    = '0;
          valid_d  = 1'b0;
        end else if (redirect) begin
          pc_d    = npc;
          instr_d = NOP_INSTR;
          pp4_d   = '0;
          valid_d = 1'b0;
        end else if (!hold) begin
          pc_d    = npc;
          instr_d = imem_rdata;
          pp4_d   = seq;
          valid_d = 1'b1;
        end
      end
      ST_HALTED, ST_FAULT: begin
        instr_d = NOP_INSTR;
        pp4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        instr_d = NOP_INSTR;
        pp4_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pp4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp4_q    <= pp4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 10-word Imem model (mem[i] = 0x1000_0000 | i).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd40 && imem_addr[1:0] == 2'b00)
      imem_rdata = 32'h1000_0000 | (imem_addr >> 2);
    else
      imem_rdata = 32'hDEAD_BEEF;
  end

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .halt           (halt),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; branch_taken = 0; jump = 0; halt = 0;
    branch_offset = '0; jump_index = '0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'd0); end
    checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'd0); end
    checks++; if (if_id_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pp4: got %h expected %h", if_id_pc_plus4, 32'd0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%b fault=%b expected 0 0", halted, fault); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_instr [4] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
    logic [31:0] exp_pc [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL run_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
      checks++; if (if_id_instr !== exp_instr[i]) begin errors++; $display("FAIL run_instr[%0d]: got %h expected %h", i, if_id_instr, exp_instr[i]); end
      checks++; if (if_id_pc_plus4 !== exp_pc[i]) begin errors++; $display("FAIL run_pp4[%0d]: got %h expected %h", i, if_id_pc_plus4, exp_pc[i]); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d]: got %b expected 1", i, if_id_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'd8); end
      checks++; if (if_id_instr !== 32'h1000_0001 || if_id_pc_plus4 !== 32'd8 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected 10000001/00000008/1", i, if_id_instr, if_id_pc_plus4, if_id_valid);
      end
    end
    stall = 0;
    tick();
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'd12); end
    checks++; if (if_id_instr !== 32'h1000_0002) begin errors++; $display("FAIL stall_release_instr: got %h expected %h", if_id_instr, 32'h1000_0002); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    branch_taken = 1; branch_offset = 16'hFFFE;
    tick();
    branch_taken = 0;
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL branch_pc: got %h expected %h", pc, 32'd4); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin
      errors++; $display("FAIL branch_bubble: got %h/%h/%b expected 0/0/0", if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    tick();
    checks++; if (if_id_instr !== 32'h1000_0001 || if_id_pc_plus4 !== 32'd8 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL branch_target: got %h/%h/%b expected 10000001/00000008/1", if_id_instr, if_id_pc_plus4, if_id_valid);
    end
  endtask

  task automatic test_jump();
    do_reset();
    tick(); tick(); tick();
    branch_taken = 1; branch_offset = 16'hFFFE; jump = 1; jump_index = 26'd5;
    tick();
    branch_taken = 0; jump = 0;
    checks++; if (pc !== 32'd20) begin errors++; $display("FAIL jump_pc: got %h expected %h", pc, 32'd20); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0) begin errors++; $display("FAIL jump_bubble: got %h/%b expected 0/0", if_id_instr, if_id_valid); end
    tick();
    checks++; if (if_id_instr !== 32'h1000_0005 || if_id_pc_plus4 !== 32'd24 || pc !== 32'd24) begin
      errors++; $display("FAIL jump_target: got %h/%h pc=%h expected 10000005/00000018 pc=00000018", if_id_instr, if_id_pc_plus4, pc);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    tick(); tick(); tick();
    branch_taken = 1; branch_offset = 16'hFFFE; stall = 1;
    tick();
    stall = 0;
    checks++; if (pc !== 32'd4 || if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_stall: got pc=%h valid=%b expected pc=00000004 valid=0", pc, if_id_valid); end
    tick();
    branch_taken = 0;
    checks++; if (pc !== 32'd8 || if_id_instr !== 32'h1000_0001 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL redir_ignored: got pc=%h instr=%h valid=%b expected pc=00000008 instr=10000001 valid=1", pc, if_id_instr, if_id_valid);
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (pc !== 32'd40 || if_id_instr !== 32'h1000_0009 || fault !== 1'b0) begin
      errors++; $display("FAIL fault_pre: got pc=%h instr=%h fault=%b expected pc=00000028 instr=10000009 fault=0", pc, if_id_instr, fault);
    end
    halt = 1;
    tick();
    halt = 0;
    checks++; if (fault !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL fault_flag: got fault=%b halted=%b expected 1 0", fault, halted); end
    checks++; if (pc !== 32'd40 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin
      errors++; $display("FAIL fault_freeze: got pc=%h %h/%h/%b expected 00000028 0/0/0", pc, if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    tick();
    checks++; if (pc !== 32'd40 || fault !== 1'b1) begin errors++; $display("FAIL fault_hold: got pc=%h fault=%b expected 00000028 1", pc, fault); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (pc !== 32'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_reset: got pc=%h fault=%b expected 0 0", pc, fault); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    halt = 1;
    tick();
    halt = 0;
    checks++; if (halted !== 1'b1 || pc !== 32'd24 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got halted=%b pc=%h valid=%b expected 1 00000018 0", halted, pc, if_id_valid);
    end
    branch_taken = 1; branch_offset = 16'hFFFE;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc !== 32'd24 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d]: got pc=%h halted=%b expected 00000018 1", i, pc, halted); end
    end
    reset = 1;
    tick();
    reset = 0; branch_taken = 0;
    checks++; if (halted !== 1'b0 || pc !== 32'd0) begin errors++; $display("FAIL halt_reset: got halted=%b pc=%h expected 0 0", halted, pc); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_jump();
    test_redirect_stall();
    test_fault();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
